hid_mouse_tracker: RTL and testbench

HID_MOUSE_TRACKER -- requirements
Module: hid_mouse_tracker

---
 rtl/hid_pkg.sv | 20 ++
 rtl/hid_axis_clamp.sv | 42 ++++
 rtl/hid_mouse_tracker.sv | 159 +++++++++++++++
 tb/tb_hid_mouse_tracker.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hid_pkg.sv
// Shared report layout, button bit positions and tracker FSM encoding.
package hid_pkg;

  localparam int BYTE_BUTTONS = 0;
  localparam int BYTE_DX      = 1;
  localparam int BYTE_DY      = 2;
  localparam int BYTE_WHEEL   = 3;

  localparam int BTN_LEFT   = 0;
  localparam int BTN_RIGHT  = 1;
  localparam int BTN_MIDDLE = 2;
  localparam int NUM_BTN    = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CALC   = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

endpackage

// File: rtl/hid_axis_clamp.sv
// One cursor axis: sign-extend the delta, add to the current position, clamp to [0, C_max].
// The sum is registered while calc_en is high; the clamped value is combinational from it.
module hid_axis_clamp #(
  parameter int C_max = 639
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       calc_en,
  input  logic [7:0] delta,
  input  logic [9:0] cur,
  output logic [9:0] pos
);

  logic signed [11:0] sum_d;
  logic signed [11:0] sum_q;

  always_comb begin
    sum_d = sum_q;
    if (calc_en) begin
      sum_d = $signed({{4{delta[7]}}, delta}) + $signed({2'b00, cur});
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  always_comb begin
    if (sum_q < 12'sd0) begin
      pos = '0;
    end else if (sum_q > $signed(12'(C_max))) begin
      pos = 10'(C_max);
    end else begin
      pos = sum_q[9:0];
    end
  end

endmodule

// File: rtl/hid_mouse_tracker.sv
// Turns HID boot-mouse reports into clamped cursor, wheel and button state; 3-cycle latency.
// No backpressure: hid_valid arriving while a report is being processed is dropped.
module hid_mouse_tracker
  import hid_pkg::*;
#(
  parameter int C_report_length = 20,
  parameter int C_x_max         = 639,
  parameter int C_y_max         = 479,
  parameter int C_timeout       = 60000
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [C_report_length*8-1:0] hid_report,
  input  logic                         hid_valid,
  output logic [9:0]                   mouse_x,
  output logic [9:0]                   mouse_y,
  output logic [7:0]                   wheel,
  output logic [NUM_BTN-1:0]           buttons,
  output logic [NUM_BTN-1:0]           btn_press,
  output logic [NUM_BTN-1:0]           btn_release,
  output logic                         update,
  output logic                         connected,
  output logic [15:0]                  report_count
);

  localparam int              CW      = $clog2(C_timeout + 1);
  localparam logic [CW-1:0]   TIMEOUT = CW'(C_timeout);
  localparam logic [9:0]      X_RST   = 10'((C_x_max + 1) / 2);
  localparam logic [9:0]      Y_RST   = 10'((C_y_max + 1) / 2);

  state_t             state_q, state_d;
  logic [NUM_BTN-1:0] btn_cap_q, btn_cap_d;
  logic [7:0]         dx_q, dx_d, dy_q, dy_d, dw_q, dw_d;
  logic [7:0]         wheel_sum_q, wheel_sum_d;
  logic [9:0]         mouse_x_q, mouse_x_d, mouse_y_q, mouse_y_d;
  logic [7:0]         wheel_q, wheel_d;
  logic [NUM_BTN-1:0] buttons_q, buttons_d, btn_press_q, btn_press_d, btn_release_q, btn_release_d;
  logic               update_q, update_d, connected_q, connected_d;
  logic [15:0]        report_count_q, report_count_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               accept;
  logic               calc_en;
  logic [9:0]         x_next, y_next;
  logic               unused_report_bits;

  // Only bytes 0-3 and the three button bits of byte 0 carry meaning.
  assign unused_report_bits = ^{hid_report[C_report_length*8-1:32], hid_report[7:NUM_BTN]};

  assign accept  = hid_valid && (state_q == ST_IDLE);
  assign calc_en = (state_q == ST_CALC);

  hid_axis_clamp #(.C_max(C_x_max)) u_x_clamp (
    .clk(clk), .reset(reset), .calc_en(calc_en), .delta(dx_q), .cur(mouse_x_q), .pos(x_next)
  );

  hid_axis_clamp #(.C_max(C_y_max)) u_y_clamp (
    .clk(clk), .reset(reset), .calc_en(calc_en), .delta(dy_q), .cur(mouse_y_q), .pos(y_next)
  );

  always_comb begin
    state_d        = state_q;
    btn_cap_d      = btn_cap_q;
    dx_d           = dx_q;
    dy_d           = dy_q;
    dw_d           = dw_q;
    wheel_sum_d    = wheel_sum_q;
    mouse_x_d      = mouse_x_q;
    mouse_y_d      = mouse_y_q;
    wheel_d        = wheel_q;
    buttons_d      = buttons_q;
    btn_press_d    = '0;
    btn_release_d  = '0;
    update_d       = 1'b0;
    report_count_d = report_count_q;

    case (state_q)
      ST_IDLE: begin
        if (hid_valid) begin
          state_d               = ST_CALC;
          btn_cap_d[BTN_LEFT]   = hid_report[8*BYTE_BUTTONS + BTN_LEFT];
          btn_cap_d[BTN_RIGHT]  = hid_report[8*BYTE_BUTTONS + BTN_RIGHT];
          btn_cap_d[BTN_MIDDLE] = hid_report[8*BYTE_BUTTONS + BTN_MIDDLE];
          dx_d                  = hid_report[8*BYTE_DX +: 8];
          dy_d                  = hid_report[8*BYTE_DY +: 8];
          dw_d                  = hid_report[8*BYTE_WHEEL +: 8];
        end
      end
      ST_CALC: begin
        state_d     = ST_COMMIT;
        wheel_sum_d = wheel_q + dw_q;
      end
      ST_COMMIT: begin
        state_d        = ST_IDLE;
        mouse_x_d      = x_next;
        mouse_y_d      = y_next;
        wheel_d        = wheel_sum_q;
        buttons_d      = btn_cap_q;
        btn_press_d    = btn_cap_q & ~buttons_q;
        btn_release_d  = ~btn_cap_q & buttons_q;
        update_d       = 1'b1;
        report_count_d = report_count_q + 16'd1;
      end
      default: state_d = ST_IDLE;
    endcase

    // Link watchdog: saturating idle counter, cleared on each accepted report.
    cnt_d       = accept ? '0 : ((cnt_q == TIMEOUT) ? cnt_q : cnt_q + 1'b1);
    connected_d = accept ? 1'b1 : ((cnt_d == TIMEOUT) ? 1'b0 : connected_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      btn_cap_q      <= '0;
      dx_q           <= '0;
      dy_q           <= '0;
      dw_q           <= '0;
      wheel_sum_q    <= '0;
      mouse_x_q      <= X_RST;
      mouse_y_q      <= Y_RST;
      wheel_q        <= '0;
      buttons_q      <= '0;
      btn_press_q    <= '0;
      btn_release_q  <= '0;
      update_q       <= 1'b0;
      report_count_q <= '0;
      cnt_q          <= TIMEOUT;
      connected_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      btn_cap_q      <= btn_cap_d;
      dx_q           <= dx_d;
      dy_q           <= dy_d;
      dw_q           <= dw_d;
      wheel_sum_q    <= wheel_sum_d;
      mouse_x_q      <= mouse_x_d;
      mouse_y_q      <= mouse_y_d;
      wheel_q        <= wheel_d;
      buttons_q      <= buttons_d;
      btn_press_q    <= btn_press_d;
      btn_release_q  <= btn_release_d;
      update_q       <= update_d;
      report_count_q <= report_count_d;
      cnt_q          <= cnt_d;
      connected_q    <= connected_d;
    end
  end

  assign mouse_x      = mouse_x_q;
  assign mouse_y      = mouse_y_q;
  assign wheel        = wheel_q;
  assign buttons      = buttons_q;
  assign btn_press    = btn_press_q;
  assign btn_release  = btn_release_q;
  assign update       = update_q;
  assign connected    = connected_q;
  assign report_count = report_count_q;

endmodule

// File: tb/tb_hid_mouse_tracker.sv
// Scoreboard bench for hid_mouse_tracker with a short link timeout.
module tb_hid_mouse_tracker;

  localparam int RLEN  = 20;
  localparam int X_MAX = 639;
  localparam int Y_MAX = 479;
  localparam int TOUT  = 100;

  typedef struct {
    logic [9:0]  x;
    logic [9:0]  y;
    logic [7:0]  w;
    logic [2:0]  b;
    logic [2:0]  pr;
    logic [2:0]  rl;
    logic [15:0] cnt;
  } exp_t;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [RLEN*8-1:0] hid_report = '0;
  logic            hid_valid = 1'b0;
  logic [9:0]      mouse_x, mouse_y;
  logic [7:0]      wheel;
  logic [2:0]      buttons, btn_press, btn_release;
  logic            update, connected;
  logic [15:0]     report_count;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  exp_t mon_e;

  int          m_x, m_y;
  logic [7:0]  m_w;
  logic [2:0]  m_b;
  logic [15:0] m_cnt;

  hid_mouse_tracker #(
    .C_report_length(RLEN), .C_x_max(X_MAX), .C_y_max(Y_MAX), .C_timeout(TOUT)
  ) dut (
    .clk(clk), .reset(reset), .hid_report(hid_report), .hid_valid(hid_valid),
    .mouse_x(mouse_x), .mouse_y(mouse_y), .wheel(wheel), .buttons(buttons),
    .btn_press(btn_press), .btn_release(btn_release), .update(update),
    .connected(connected), .report_count(report_count)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  // Every update pulse must match the oldest expected report result.
  always @(posedge clk) begin
    #1;
    if (update === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_update got update=1 required no pending report");
      end else begin
        mon_e = exp_q.pop_front();
        if ({mouse_x, mouse_y, wheel, buttons, btn_press, btn_release, report_count} !==
            {mon_e.x, mon_e.y, mon_e.w, mon_e.b, mon_e.pr, mon_e.rl, mon_e.cnt}) begin
          errors++;
          $display("FAIL scoreboard got x=%0d y=%0d w=%h b=%b pr=%b rl=%b cnt=%0d required x=%0d y=%0d w=%h b=%b pr=%b rl=%b cnt=%0d",
                   mouse_x, mouse_y, wheel, buttons, btn_press, btn_release, report_count,
                   mon_e.x, mon_e.y, mon_e.w, mon_e.b, mon_e.pr, mon_e.rl, mon_e.cnt);
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset;
    m_x   = (X_MAX + 1) / 2;
    m_y   = (Y_MAX + 1) / 2;
    m_w   = 8'h00;
    m_b   = 3'b000;
    m_cnt = 16'd0;
  endtask

  // Drives one report with hid_valid held for 'hold' cycles; returns just after the accept edge.
  task automatic send(input logic [7:0] b0, input logic [7:0] dx, input logic [7:0] dy,
                      input logic [7:0] dw, input int hold, input bit expect_it);
    exp_t e;
    int   nx, ny;
    for (int k = 4; k < RLEN; k++) hid_report[8*k +: 8] = 8'($urandom);
    hid_report[7:0]   = {5'($urandom), b0[2:0]};
    hid_report[15:8]  = dx;
    hid_report[23:16] = dy;
    hid_report[31:24] = dw;
    if (expect_it) begin
      nx = m_x + int'($signed(dx));
      ny = m_y + int'($signed(dy));
      if (nx < 0) nx = 0; else if (nx > X_MAX) nx = X_MAX;
      if (ny < 0) ny = 0; else if (ny > Y_MAX) ny = Y_MAX;
      e.x   = 10'(nx);
      e.y   = 10'(ny);
      e.w   = m_w + dw;
      e.b   = b0[2:0];
      e.pr  = b0[2:0] & ~m_b;
      e.rl  = ~b0[2:0] & m_b;
      e.cnt = m_cnt + 16'd1;
      exp_q.push_back(e);
      m_x = nx; m_y = ny; m_w = e.w; m_b = e.b; m_cnt = e.cnt;
    end
    hid_valid = 1'b1;
    for (int i = 0; i < hold; i++) tick();
    hid_valid = 1'b0;
  endtask

  task automatic await_done;
    int n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL await_update pending=%0d required 0 within 20 cycles", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    model_reset();
    checks++; if (mouse_x !== 10'd320) begin errors++; $display("FAIL reset_x got %0d required 320", mouse_x); end
    checks++; if (mouse_y !== 10'd240) begin errors++; $display("FAIL reset_y got %0d required 240", mouse_y); end
    checks++; if (connected !== 1'b0) begin errors++; $display("FAIL reset_connected got %b required 0", connected); end
    checks++;
    if ({wheel, buttons, btn_press, btn_release, update, report_count} !== 31'd0) begin
      errors++;
      $display("FAIL reset_zero got w=%h b=%b pr=%b rl=%b upd=%b cnt=%0d required all 0",
               wheel, buttons, btn_press, btn_release, update, report_count);
    end
  endtask

  task automatic test_basic;
    send(8'h01, 8'h05, 8'hFD, 8'h01, 1, 1'b1);
    checks++; if (update !== 1'b0) begin errors++; $display("FAIL basic_latency1 update=%b required 0", update); end
    tick();
    checks++; if (update !== 1'b0) begin errors++; $display("FAIL basic_latency2 update=%b required 0", update); end
    tick();
    checks++; if (update !== 1'b1) begin errors++; $display("FAIL basic_latency3 update=%b required 1", update); end
    checks++;
    if ({mouse_x, mouse_y, wheel, buttons, btn_press, report_count} !==
        {10'd325, 10'd237, 8'h01, 3'b001, 3'b001, 16'd1}) begin
      errors++;
      $display("FAIL basic_values got x=%0d y=%0d w=%h b=%b pr=%b cnt=%0d required x=325 y=237 w=01 b=001 pr=001 cnt=1",
               mouse_x, mouse_y, wheel, buttons, btn_press, report_count);
    end
    checks++; if (connected !== 1'b1) begin errors++; $display("FAIL basic_connected got %b required 1", connected); end
    await_done();
  endtask

  task automatic test_clamp;
    logic [7:0] xs[7] = '{8'h80, 8'h80, 8'hBE, 8'h7F, 8'h7F, 8'h7F, 8'h7F};
    for (int i = 0; i < 3; i++) begin send(8'h01, xs[i], 8'h00, 8'h00, 1, 1'b1); await_done(); end
    checks++; if (mouse_x !== 10'd3) begin errors++; $display("FAIL clamp_x_setup got %0d required 3", mouse_x); end
    send(8'h01, 8'h80, 8'h00, 8'h00, 1, 1'b1); await_done();
    checks++; if (mouse_x !== 10'd0) begin errors++; $display("FAIL clamp_x_low got %0d required 0", mouse_x); end
    for (int i = 3; i < 7; i++) begin send(8'h01, xs[i], 8'h00, 8'h00, 1, 1'b1); await_done(); end
    send(8'h01, 8'h7A, 8'h00, 8'h00, 1, 1'b1); await_done();
    checks++; if (mouse_x !== 10'd630) begin errors++; $display("FAIL clamp_x_setup2 got %0d required 630", mouse_x); end
    send(8'h01, 8'h7F, 8'h00, 8'h00, 1, 1'b1); await_done();
    checks++; if (mouse_x !== 10'd639) begin errors++; $display("FAIL clamp_x_high got %0d required 639", mouse_x); end
    send(8'h01, 8'h00, 8'h80, 8'h00, 1, 1'b1); await_done();
    send(8'h01, 8'h00, 8'h96, 8'h00, 1, 1'b1); await_done();
    send(8'h01, 8'h00, 8'h80, 8'h00, 1, 1'b1); await_done();
    checks++; if (mouse_y !== 10'd0) begin errors++; $display("FAIL clamp_y_low got %0d required 0", mouse_y); end
    for (int i = 0; i < 3; i++) begin send(8'h01, 8'h00, 8'h7F, 8'h00, 1, 1'b1); await_done(); end
    send(8'h01, 8'h00, 8'h59, 8'h00, 1, 1'b1); await_done();
    send(8'h01, 8'h00, 8'h7F, 8'h00, 1, 1'b1); await_done();
    checks++; if (mouse_y !== 10'd479) begin errors++; $display("FAIL clamp_y_high got %0d required 479", mouse_y); end
  endtask

  task automatic test_wheel;
    send(8'h01, 8'h00, 8'h00, 8'hFE, 1, 1'b1); await_done();
    send(8'h01, 8'h00, 8'h00, 8'h01, 1, 1'b1); await_done();
    checks++; if (wheel !== 8'h00) begin errors++; $display("FAIL wheel_wrap_up got %h required 00", wheel); end
    send(8'h01, 8'h00, 8'h00, 8'hFF, 1, 1'b1); await_done();
    checks++; if (wheel !== 8'hFF) begin errors++; $display("FAIL wheel_wrap_down got %h required ff", wheel); end
  endtask

  task automatic test_buttons;
    int n = 0;
    send(8'h03, 8'h00, 8'h00, 8'h00, 1, 1'b1); await_done();
    send(8'h06, 8'h00, 8'h00, 8'h00, 1, 1'b1);
    while (update !== 1'b1 && n < 10) begin tick(); n++; end
    checks++;
    if (btn_press !== 3'b100 || btn_release !== 3'b001) begin
      errors++;
      $display("FAIL btn_edges got pr=%b rl=%b required pr=100 rl=001", btn_press, btn_release);
    end
    tick();
    checks++;
    if (btn_press !== 3'b000 || btn_release !== 3'b000 || update !== 1'b0) begin
      errors++;
      $display("FAIL btn_one_cycle got pr=%b rl=%b upd=%b required 000 000 0", btn_press, btn_release, update);
    end
    await_done();
  endtask

  task automatic test_back_to_back;
    logic [15:0] c0 = m_cnt;
    send(8'h00, 8'h02, 8'h02, 8'h00, 2, 1'b1);
    await_done();
    checks++;
    if (report_count !== c0 + 16'd1) begin
      errors++;
      $display("FAIL b2b_ignored got cnt=%0d required %0d", report_count, c0 + 16'd1);
    end
    send(8'h00, 8'h03, 8'h01, 8'h00, 1, 1'b1);
    tick(); tick();
    send(8'h01, 8'hFE, 8'hFF, 8'h02, 1, 1'b1);
    await_done();
    checks++;
    if (report_count !== c0 + 16'd3) begin
      errors++;
      $display("FAIL b2b_accepted got cnt=%0d required %0d", report_count, c0 + 16'd3);
    end
  endtask

  task automatic test_timeout;
    send(8'h01, 8'h01, 8'h01, 8'h00, 1, 1'b1);
    for (int i = 0; i < TOUT - 1; i++) tick();
    checks++; if (connected !== 1'b1) begin errors++; $display("FAIL timeout_early got connected=%b required 1", connected); end
    tick();
    checks++; if (connected !== 1'b0) begin errors++; $display("FAIL timeout_fall got connected=%b required 0", connected); end
    checks++;
    if (mouse_x !== 10'(m_x) || mouse_y !== 10'(m_y) || buttons !== m_b) begin
      errors++;
      $display("FAIL timeout_hold got x=%0d y=%0d b=%b required x=%0d y=%0d b=%b",
               mouse_x, mouse_y, buttons, m_x, m_y, m_b);
    end
  endtask

  task automatic test_reset_inflight;
    bit seen = 1'b0;
    send(8'h07, 8'h10, 8'h10, 8'h10, 1, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 8; i++) begin
      tick();
      if (update === 1'b1) seen = 1'b1;
    end
    checks++; if (seen) begin errors++; $display("FAIL inflight_discard got update pulse required none"); end
    checks++;
    if (mouse_x !== 10'd320 || report_count !== 16'd0 || buttons !== 3'b000) begin
      errors++;
      $display("FAIL inflight_state got x=%0d cnt=%0d b=%b required x=320 cnt=0 b=000",
               mouse_x, report_count, buttons);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_clamp();
    test_wheel();
    test_buttons();
    test_back_to_back();
    test_timeout();
    test_reset_inflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
